// File: rtl/data_receiver_pkg.sv
// data_receiver shared constants: widths, state encodings, edge bundle.
// Optional stall timeout is enabled with DATA_RECEIVER_TIMEOUT_EN.
package data_receiver_pkg;

    localparam int DATA_RECEIVER_WIDTH = 64;
    localparam int DATA_RECEIVER_SYNC = 2;
    localparam int DATA_RECEIVER_TIMEOUT = 1000000;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECEIVE = 2'd1;
    localparam logic [1:0] WAIT_END = 2'd2;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } link_edge_t;

endpackage

// File: rtl/data_receiver_if.sv
// data_receiver link bundle: three-wire serial input plus word output.
// master drives the link, slave is the receiver.
interface data_receiver_if
    import data_receiver_pkg::*;
#(
    parameter int WIDTH = DATA_RECEIVER_WIDTH
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_transmission;
    logic             in_clock;
    logic             in_data;
    logic [WIDTH-1:0] out_data;
    logic             valid;
    logic             frame_error;
    logic             busy;
    logic [CW-1:0]    bit_count;

    modport master (
        output in_transmission,
        output in_clock,
        output in_data,
        input  out_data,
        input  valid,
        input  frame_error,
        input  busy,
        input  bit_count
    );

    modport slave (
        input  in_transmission,
        input  in_clock,
        input  in_data,
        output out_data,
        output valid,
        output frame_error,
        output busy,
        output bit_count
    );

endinterface

// File: rtl/data_receiver_sync_edge.sv
// Multi-flop synchroniser with registered level / rise / fall outputs.
// Edges are suppressed until the chain holds only post-reset samples.
module data_receiver_sync_edge
    import data_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = DATA_RECEIVER_SYNC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output link_edge_t ev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   last;
    logic                   primed;

    assign last   = sync_q[SYNC_STAGES-1];
    // A line already high at reset release must not look like a rise.
    assign primed = &fill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            fill_q <= '0;
            ev     <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q   <= last;
            fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            ev.level <= last;
            ev.rise  <= primed & last & ~prev_q;
            ev.fall  <= primed & ~last & prev_q;
        end
    end

endmodule

// File: rtl/data_receiver.sv
// Three-wire serial link deserialiser, MSB-first, with framing checks.
// Define DATA_RECEIVER_TIMEOUT_EN to abort frames whose link clock stalls.
module data_receiver
    import data_receiver_pkg::*;
#(
    parameter int WIDTH          = DATA_RECEIVER_WIDTH,
    parameter int SYNC_STAGES    = DATA_RECEIVER_SYNC,
    parameter int TIMEOUT_CYCLES = DATA_RECEIVER_TIMEOUT
) (
    input logic           clk,
    input logic           rst,
    data_receiver_if.slave link
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("data_receiver: SYNC_STAGES >= 2, TIMEOUT_CYCLES >= 1");
    end

    link_edge_t trans_e;
    link_edge_t clock_e;
    link_edge_t data_e;

    data_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_trans (
        .clk (clk),
        .rst (rst),
        .din (link.in_transmission),
        .ev  (trans_e)
    );

    data_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clock (
        .clk (clk),
        .rst (rst),
        .din (link.in_clock),
        .ev  (clock_e)
    );

    data_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data (
        .clk (clk),
        .rst (rst),
        .din (link.in_data),
        .ev  (data_e)
    );

    logic [1:0]       state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] out_q;
    logic [CW-1:0]    cnt_q;
    logic             ovr_q;
    logic             valid_q;
    logic             err_q;

    logic [WIDTH-1:0] shift_n;
    logic [CW-1:0]    cnt_n;
    logic             ovr_n;
    logic             take;
    logic             good;
    logic             tmo_hit;

    assign take = (state_q == RECEIVE) && clock_e.rise;

    // The bit of this cycle is folded in before the end-of-frame check.
    always_comb begin
        shift_n = shift_q;
        cnt_n   = cnt_q;
        ovr_n   = ovr_q;
        if (take) begin
            if (cnt_q == FULL) begin
                ovr_n = 1'b1;
            end else begin
                shift_n = {shift_q[WIDTH-2:0], data_e.level};
                cnt_n   = cnt_q + 1'b1;
            end
        end
        good = (cnt_n == FULL) && !ovr_n;
    end

`ifdef DATA_RECEIVER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q;

    assign tmo_hit = (state_q == RECEIVE) && !take && (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst || state_q != RECEIVE || take) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (1'b1)
                (state_q == IDLE): begin
                    if (trans_e.rise) begin
                        state_q <= RECEIVE;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        ovr_q   <= 1'b0;
                    end
                end
                (state_q == RECEIVE): begin
                    shift_q <= shift_n;
                    cnt_q   <= cnt_n;
                    ovr_q   <= ovr_n;
                    if (trans_e.fall) begin
                        state_q <= IDLE;
                        if (good) begin
                            out_q   <= shift_n;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state_q <= WAIT_END;
                        err_q   <= 1'b1;
                    end
                end
`ifdef DATA_RECEIVER_TIMEOUT_EN
                (state_q == WAIT_END): begin
                    if (trans_e.fall) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign link.out_data    = out_q;
    assign link.valid       = valid_q;
    assign link.frame_error = err_q;
    assign link.busy        = (state_q != IDLE);
    assign link.bit_count   = cnt_q;

endmodule

// File: tb/tb_data_receiver.sv
// Self-checking bench for data_receiver: random frames vs a bit-queue model.
// Timeout scenario runs only when DATA_RECEIVER_TIMEOUT_EN is defined.
module tb_data_receiver;
    import data_receiver_pkg::*;

    localparam int W   = 64;
    localparam int S   = 2;
    localparam int TMO = 50;
    localparam int CW  = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_receiver_if #(.WIDTH(W)) link ();

    data_receiver #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int n_valid = 0;
    int n_err = 0;
    int overlap = 0;
    int long_pulse = 0;
    int valid_cyc = -1;
    int err_cyc = -1;
    int fall_cyc = -1;
    logic [W-1:0] last_word = '0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    always @(negedge clk) begin
        if (link.valid === 1'b1) begin
            n_valid++;
            last_word = link.out_data;
            valid_cyc = cyc;
        end
        if (link.frame_error === 1'b1) begin
            n_err++;
            err_cyc = cyc;
        end
        if (link.valid === 1'b1 && link.frame_error === 1'b1) overlap++;
        if (link.valid === 1'b1 && prev_v) long_pulse++;
        if (link.frame_error === 1'b1 && prev_e) long_pulse++;
        prev_v = (link.valid === 1'b1);
        prev_e = (link.frame_error === 1'b1);
    end

    // Model outcome of the last frame sent
    bit           m_ok;
    logic [W-1:0] m_word;
    logic [CW-1:0] bc_end;
    logic         busy_mid;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame; the model keeps every sampled bit in a queue
    task automatic send_frame(input logic [W-1:0] word, input int nedges,
                              input int half, input bit merge, input int tail);
        bit q[$];
        logic b;
        @(negedge clk);
        link.in_clock = 1'b0;
        link.in_transmission = 1'b1;
        wait_clk(half);
        for (int i = 0; i < nedges; i++) begin
            b = (i < W) ? word[W-1-i] : 1'($urandom);
            link.in_data = b;
            q.push_back(b);
            wait_clk(half);
            if (merge && i == nedges - 1) begin
                busy_mid = link.busy;
                bc_end = link.bit_count;
                link.in_clock = 1'b1;
                link.in_transmission = 1'b0;
                fall_cyc = cyc;
                wait_clk(half);
                link.in_clock = 1'b0;
            end else begin
                link.in_clock = 1'b1;
                wait_clk(half);
                link.in_clock = 1'b0;
            end
        end
        if (!merge || nedges == 0) begin
            wait_clk(half);
            busy_mid = link.busy;
            bc_end = link.bit_count;
            link.in_transmission = 1'b0;
            fall_cyc = cyc;
        end
        m_ok = (q.size() == W);
        m_word = '0;
        if (m_ok) begin
            foreach (q[k]) m_word = {m_word[W-2:0], q[k]};
        end
        wait_clk(tail);
    endtask

    task automatic test_reset();
        link.in_transmission = 1'b0;
        link.in_clock = 1'b0;
        link.in_data = 1'b0;
        rst = 1'b1;
        wait_clk(5);
        checks++;
        if (link.out_data !== '0 || link.valid !== 1'b0 ||
            link.frame_error !== 1'b0 || link.busy !== 1'b0 ||
            link.bit_count !== '0) begin
            failures++;
            $display("FAIL reset: out=%h v=%b e=%b busy=%b bc=%0d want all 0",
                     link.out_data, link.valid, link.frame_error,
                     link.busy, link.bit_count);
        end
        rst = 1'b0;
        wait_clk(S + 4);
    endtask

    task automatic test_basic();
        int v0 = n_valid;
        int e0 = n_err;
        send_frame(64'h80C0E0F0F8FCFEFF, W, 8, 1'b0, S + 8);
        checks++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
            failures++;
            $display("FAIL basic_pulses: valid=%0d err=%0d want 1 0",
                     n_valid - v0, n_err - e0);
        end
        checks++;
        if (last_word !== 64'h80C0E0F0F8FCFEFF) begin
            failures++;
            $display("FAIL basic_word: got %h want 80c0e0f0f8fcfeff",
                     last_word);
        end
        checks++;
        if (valid_cyc - fall_cyc !== S + 2) begin
            failures++;
            $display("FAIL basic_latency: got %0d want %0d",
                     valid_cyc - fall_cyc, S + 2);
        end
        checks++;
        if (busy_mid !== 1'b1 || link.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: mid=%b after=%b want 1 0",
                     busy_mid, link.busy);
        end
    endtask

    task automatic test_short();
        int v0 = n_valid;
        int e0 = n_err;
        logic [W-1:0] prev = link.out_data;
        send_frame({$urandom, $urandom}, W - 1, 8, 1'b0, S + 8);
        checks++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 1) begin
            failures++;
            $display("FAIL short_pulses: valid=%0d err=%0d want 0 1",
                     n_valid - v0, n_err - e0);
        end
        checks++;
        if (link.out_data !== prev) begin
            failures++;
            $display("FAIL short_hold: out=%h want %h", link.out_data, prev);
        end
        send_frame(64'hAAAAAAAAAAAAAAAA, W, 8, 1'b0, S + 8);
        checks++;
        if (n_valid - v0 !== 1 || link.out_data !== 64'hAAAAAAAAAAAAAAAA) begin
            failures++;
            $display("FAIL short_recover: valid=%0d out=%h want 1 aaaa..",
                     n_valid - v0, link.out_data);
        end
    endtask

    task automatic test_long();
        int v0 = n_valid;
        int e0 = n_err;
        send_frame({$urandom, $urandom}, W + 1, 8, 1'b0, S + 8);
        checks++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 1) begin
            failures++;
            $display("FAIL long_pulses: valid=%0d err=%0d want 0 1",
                     n_valid - v0, n_err - e0);
        end
        checks++;
        if (bc_end !== CW'(W)) begin
            failures++;
            $display("FAIL long_bitcount: got %0d want %0d", bc_end, W);
        end
        send_frame(64'h0123456789ABCDEF, W, 5, 1'b0, S + 8);
        checks++;
        if (n_valid - v0 !== 1 || last_word !== 64'h0123456789ABCDEF) begin
            failures++;
            $display("FAIL long_recover: valid=%0d out=%h want 1 0123..",
                     n_valid - v0, last_word);
        end
    endtask

    task automatic test_reset_mid();
        int v0 = n_valid;
        int e0 = n_err;
        int bad_busy = 0;
        @(negedge clk);
        link.in_transmission = 1'b1;
        wait_clk(6);
        for (int i = 0; i < 20; i++) begin
            link.in_data = 1'($urandom);
            wait_clk(6);
            link.in_clock = 1'b1;
            wait_clk(6);
            link.in_clock = 1'b0;
        end
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            link.in_data = 1'($urandom);
            wait_clk(6);
            if (link.busy !== 1'b0) bad_busy++;
            link.in_clock = 1'b1;
            wait_clk(6);
            if (link.busy !== 1'b0) bad_busy++;
            link.in_clock = 1'b0;
        end
        link.in_transmission = 1'b0;
        wait_clk(S + 8);
        checks++;
        if (bad_busy !== 0 || link.busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_busy: busy cycles=%0d want 0", bad_busy);
        end
        checks++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin
            failures++;
            $display("FAIL rstmid_pulses: valid=%0d err=%0d want 0 0",
                     n_valid - v0, n_err - e0);
        end
        send_frame(64'h0000000000000001, W, 6, 1'b0, S + 8);
        checks++;
        if (n_valid - v0 !== 1 || last_word !== 64'h1) begin
            failures++;
            $display("FAIL rstmid_next: valid=%0d out=%h want 1 1",
                     n_valid - v0, last_word);
        end
    endtask

    task automatic test_simul();
        int v0 = n_valid;
        int e0 = n_err;
        send_frame('1, W, 7, 1'b1, S + 8);
        checks++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0 || last_word !== '1) begin
            failures++;
            $display("FAIL simul: valid=%0d err=%0d out=%h want 1 0 ffff..",
                     n_valid - v0, n_err - e0, last_word);
        end
    endtask

    task automatic test_zero_bits();
        int e0 = n_err;
        send_frame('0, 0, 6, 1'b0, S + 8);
        checks++;
        if (n_err - e0 !== 1) begin
            failures++;
            $display("FAIL zero_bits: err=%0d want 1", n_err - e0);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int v0 = n_valid;
            int e0 = n_err;
            int r = $urandom_range(0, 3);
            int n = (r == 0) ? W - 1 : (r == 1) ? W + 1 : W;
            logic [W-1:0] old = link.out_data;
            send_frame({$urandom, $urandom}, n, $urandom_range(3, 9),
                       1'($urandom), S + 6);
            checks++;
            if (m_ok) begin
                if (n_valid - v0 !== 1 || n_err - e0 !== 0 ||
                    link.out_data !== m_word) begin
                    failures++;
                    $display("FAIL random_%0d: v=%0d e=%0d out=%h want 1 0 %h",
                             f, n_valid - v0, n_err - e0, link.out_data, m_word);
                end
            end else begin
                if (n_valid - v0 !== 0 || n_err - e0 !== 1 ||
                    link.out_data !== old) begin
                    failures++;
                    $display("FAIL random_%0d: v=%0d e=%0d out=%h want 0 1 %h",
                             f, n_valid - v0, n_err - e0, link.out_data, old);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid;
        logic [W-1:0] a = {$urandom, $urandom};
        logic [W-1:0] b = {$urandom, $urandom};
        send_frame(a, W, 4, 1'b0, 2);
        send_frame(b, W, 4, 1'b0, S + 8);
        checks++;
        if (n_valid - v0 !== 2 || last_word !== b) begin
            failures++;
            $display("FAIL back_to_back: valid=%0d out=%h want 2 %h",
                     n_valid - v0, last_word, b);
        end
    endtask

`ifdef DATA_RECEIVER_TIMEOUT_EN
    task automatic test_timeout();
        int v0 = n_valid;
        int e0 = n_err;
        int t10 = -1;
        int te = -1;
        @(negedge clk);
        link.in_transmission = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 10; i++) begin
            link.in_data = 1'($urandom);
            wait_clk(4);
            link.in_clock = 1'b1;
            if (i < 9) begin
                wait_clk(4);
                link.in_clock = 1'b0;
            end
        end
        for (int k = 0; k < 70 + S; k++) begin
            @(negedge clk);
            if (t10 < 0 && link.bit_count === CW'(10)) t10 = cyc;
            if (te < 0 && link.frame_error === 1'b1) te = cyc;
        end
        checks++;
        if (t10 < 0 || te < 0 || te - t10 !== TMO) begin
            failures++;
            $display("FAIL timeout_delay: got %0d want %0d", te - t10, TMO);
        end
        checks++;
        if (link.busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_busy: busy=%b want 1", link.busy);
        end
        link.in_clock = 1'b0;
        wait_clk(4);
        link.in_transmission = 1'b0;
        wait_clk(S + 8);
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0 || link.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_end: err=%0d v=%0d busy=%b want 1 0 0",
                     n_err - e0, n_valid - v0, link.busy);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_long();
        test_reset_mid();
        test_simul();
        test_zero_bits();
        test_random();
        test_back_to_back();
`ifdef DATA_RECEIVER_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (overlap !== 0 || long_pulse !== 0) begin
            failures++;
            $display("FAIL pulse_shape: overlap=%0d long=%0d want 0 0",
                     overlap, long_pulse);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
